// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_wb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam logic [4:0] LAST_REG    = 5'd31;
  localparam int         STALL_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanned from a registered
// pointer, which moves to one past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [N-1:0]  valid_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] winner_o,
  output logic          accept_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;
  logic          found;

  // First valid requester at or after the pointer, wrapping modulo N.
  always_comb begin
    found    = 1'b0;
    winner_o = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && valid_i[cand[IW-1:0]]) begin
        found    = 1'b1;
        winner_o = cand[IW-1:0];
      end
    end
  end

  assign accept_o = en_i && found;
  assign grant_o  = accept_o ? (N'(1) << winner_o) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept_o) ptr_d = (winner_o == IW'(N - 1)) ? '0 : winner_o + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register_file write port among NUM_SRC write-back sources, after
// an optional post-reset scrub of x1..x31. Define REGFILE_WB_STATS_EN for stall counters.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter  int NUM_SRC        = 2,
  parameter  int ADDR_W         = 5,
  parameter  int DATA_W         = 32,
  parameter  bit CLEAR_ON_RESET = 1'b1,
  localparam int GW             = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] req_addr,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic                      we,
  output logic [ADDR_W-1:0]         addr_rd2,
  output logic [DATA_W-1:0]         data_rd2,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
`ifdef REGFILE_WB_STATS_EN
  , output logic [NUM_SRC*STALL_CNT_W-1:0] stall_cnt
`endif
);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q, addr_q;
  logic [DATA_W-1:0] data_q;
  logic [GW-1:0]     gid_q, win;
  logic              we_q, accept;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .clk      (clk),
    .rst_ni   (rst),
    .en_i     (state_q == RUN),
    .valid_i  (req_valid),
    .grant_o  (req_ready),
    .winner_o (win),
    .accept_o (accept)
  );

  assign win_addr = req_addr[win*ADDR_W +: ADDR_W];
  assign win_data = req_data[win*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q   <= ADDR_W'(1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      gid_q   <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          we_q   <= 1'b1;
          addr_q <= cnt_q;
          data_q <= '0;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == ADDR_W'(LAST_REG)) state_q <= RUN;
        end
        default: begin
          // x0 is hardwired: the request is consumed but never written.
          if (accept) begin
            we_q   <= (win_addr != ADDR_W'(REG_ZERO));
            addr_q <= win_addr;
            data_q <= win_data;
            gid_q  <= win;
          end else begin
            we_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign we       = we_q;
  assign addr_rd2 = addr_q;
  assign data_rd2 = data_q;
  assign grant_id = gid_q;
  assign busy     = (state_q == CLEAR);

`ifdef REGFILE_WB_STATS_EN
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_stall
    logic [STALL_CNT_W-1:0] stall_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_q <= '0;
      else if (req_valid[gi] && !req_ready[gi] && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
    assign stall_cnt[gi*STALL_CNT_W +: STALL_CNT_W] = stall_q;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (3 sources): directed scenarios
// plus randomized traffic checked against a round-robin reference model.
module tb_regfile_wb_arbiter;

  localparam int NS = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int GW = $clog2(NS);

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    req_valid;
  logic [NS*AW-1:0] req_addr;
  logic [NS*DW-1:0] req_data;
  logic [NS-1:0]    req_ready;
  logic             we;
  logic [AW-1:0]    addr_rd2;
  logic [DW-1:0]    data_rd2;
  logic [GW-1:0]    grant_id;
  logic             busy;
`ifdef REGFILE_WB_STATS_EN
  logic [NS*16-1:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int ptr_m    = 0;

  logic [DW-1:0] rf_obs [32];
  bit            x0_written;

  regfile_wb_arbiter #(
    .NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we        (we),
    .addr_rd2  (addr_rd2),
    .data_rd2  (data_rd2),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef REGFILE_WB_STATS_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in register_file: commits the write port on each rising edge.
  always @(posedge clk) begin
    if (we) begin
      rf_obs[addr_rd2] <= data_rd2;
      if (addr_rd2 == '0) x0_written <= 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  // Round-robin rule: first valid source at or after p, wrapping modulo NS.
  function automatic int model_win(input logic [NS-1:0] v, input int p);
    for (int k = 0; k < NS; k++)
      if (v[(p + k) % NS]) return (p + k) % NS;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    set_src(0, 1'b1, 5'd5, 32'hAAAA_AAAA);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (we !== 1'b0)        $display("FAIL reset_we got %b want 0", we); else n_pass++;
    n_checks++; if (addr_rd2 !== '0)    $display("FAIL reset_addr got %0d want 0", addr_rd2); else n_pass++;
    n_checks++; if (data_rd2 !== '0)    $display("FAIL reset_data got %h want 0", data_rd2); else n_pass++;
    n_checks++; if (grant_id !== '0)    $display("FAIL reset_gid got %0d want 0", grant_id); else n_pass++;
    n_checks++; if (busy !== 1'b1)      $display("FAIL reset_busy got %b want 1", busy); else n_pass++;
    n_checks++; if (req_ready !== '0)   $display("FAIL reset_ready got %b want 000", req_ready); else n_pass++;
  endtask

  task automatic test_scrub();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (req_ready !== '0) $display("FAIL scrub_ready0 got %b want 000", req_ready); else n_pass++;
    for (int c = 1; c <= 31; c++) begin
      tick();
      n_checks++; if (we !== 1'b1 || addr_rd2 !== AW'(c) || data_rd2 !== '0)
        $display("FAIL scrub_write c=%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=0", c, we, addr_rd2, data_rd2, c);
      else n_pass++;
      n_checks++; if (busy !== (c < 31)) $display("FAIL scrub_busy c=%0d got %b want %b", c, busy, c < 31); else n_pass++;
      n_checks++; if (req_ready !== ((c < 31) ? 3'b000 : 3'b001))
        $display("FAIL scrub_ready c=%0d got %b want %b", c, req_ready, (c < 31) ? 3'b000 : 3'b001);
      else n_pass++;
    end
    tick();
    n_checks++; if (we !== 1'b1 || addr_rd2 !== 5'd5 || data_rd2 !== 32'hAAAA_AAAA || grant_id !== 2'd0)
      $display("FAIL scrub_first_accept got we=%b addr=%0d data=%h gid=%0d want 1/5/aaaaaaaa/0", we, addr_rd2, data_rd2, grant_id);
    else n_pass++;
    ptr_m = 1;
    set_src(0, 1'b0, 5'd0, 32'd0);
    tick();
    n_checks++; if (we !== 1'b0 || addr_rd2 !== 5'd5) $display("FAIL scrub_idle got we=%b addr=%0d want 0/5", we, addr_rd2); else n_pass++;
    for (int r = 1; r < 32; r++) begin
      n_checks++; if (rf_obs[r] !== ((r == 5) ? 32'hAAAA_AAAA : 32'd0))
        $display("FAIL scrub_rf x%0d got %h want %h", r, rf_obs[r], (r == 5) ? 32'hAAAA_AAAA : 32'd0);
      else n_pass++;
    end
  endtask

  task automatic test_single_source();
    set_src(1, 1'b1, 5'd7, 32'h1234_5678);
    #1;
    n_checks++; if (req_ready !== 3'b010) $display("FAIL single_ready got %b want 010", req_ready); else n_pass++;
    tick();
    n_checks++; if (we !== 1'b1 || addr_rd2 !== 5'd7 || data_rd2 !== 32'h1234_5678 || grant_id !== 2'd1)
      $display("FAIL single_write got we=%b addr=%0d data=%h gid=%0d want 1/7/12345678/1", we, addr_rd2, data_rd2, grant_id);
    else n_pass++;
    ptr_m = 2;
    set_src(1, 1'b0, 5'd0, 32'd0);
    tick();
    n_checks++; if (rf_obs[7] !== 32'h1234_5678) $display("FAIL single_readback got %h want 12345678", rf_obs[7]); else n_pass++;
  endtask

  task automatic test_x0_drop();
    set_src(2, 1'b1, 5'd0, 32'hDEAD_BEEF);
    set_src(1, 1'b1, 5'd8, 32'h0000_0088);
    #1;
    n_checks++; if (req_ready !== 3'b100) $display("FAIL x0_ready got %b want 100", req_ready); else n_pass++;
    tick();
    n_checks++; if (we !== 1'b0 || grant_id !== 2'd2) $display("FAIL x0_nowrite got we=%b gid=%0d want 0/2", we, grant_id); else n_pass++;
    #1;
    n_checks++; if (req_ready !== 3'b010) $display("FAIL x0_ptr_adv got %b want 010", req_ready); else n_pass++;
    tick();
    n_checks++; if (we !== 1'b1 || addr_rd2 !== 5'd8 || grant_id !== 2'd1)
      $display("FAIL x0_follow got we=%b addr=%0d gid=%0d want 1/8/1", we, addr_rd2, grant_id);
    else n_pass++;
    set_src(1, 1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (req_ready !== 3'b100) $display("FAIL x0_ready2 got %b want 100", req_ready); else n_pass++;
    tick();
    set_src(2, 1'b0, 5'd0, 32'd0);
    ptr_m = 0;
    tick();
    n_checks++; if (x0_written !== 1'b0) $display("FAIL x0_never_written got %b want 0", x0_written); else n_pass++;
    n_checks++; if (rf_obs[8] !== 32'h88) $display("FAIL x0_x8 got %h want 00000088", rf_obs[8]); else n_pass++;
  endtask

  task automatic test_contention();
    set_src(0, 1'b1, 5'd3, 32'h11);
    set_src(1, 1'b1, 5'd4, 32'h22);
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++; if (req_ready !== ((k % 2 == 0) ? 3'b001 : 3'b010) || $countones(req_ready) > 1)
        $display("FAIL contention_ready k=%0d got %b want %b", k, req_ready, (k % 2 == 0) ? 3'b001 : 3'b010);
      else n_pass++;
      tick();
      n_checks++; if (grant_id !== GW'(k % 2) || we !== 1'b1 || addr_rd2 !== ((k % 2 == 0) ? 5'd3 : 5'd4))
        $display("FAIL contention_grant k=%0d got gid=%0d we=%b addr=%0d want %0d/1/%0d", k, grant_id, we, addr_rd2, k % 2, (k % 2 == 0) ? 3 : 4);
      else n_pass++;
    end
    ptr_m = 2;
    set_src(0, 1'b0, 5'd0, 32'd0);
    set_src(1, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_same_reg();
    set_src(0, 1'b1, 5'd9, 32'h1);
    set_src(1, 1'b1, 5'd9, 32'h2);
    #1;
    n_checks++; if (req_ready !== 3'b001) $display("FAIL samereg_ready0 got %b want 001", req_ready); else n_pass++;
    tick();
    set_src(0, 1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (req_ready !== 3'b010) $display("FAIL samereg_ready1 got %b want 010", req_ready); else n_pass++;
    tick();
    set_src(1, 1'b0, 5'd0, 32'd0);
    n_checks++; if (we !== 1'b1 || addr_rd2 !== 5'd9 || data_rd2 !== 32'h2)
      $display("FAIL samereg_port got we=%b addr=%0d data=%h want 1/9/2", we, addr_rd2, data_rd2);
    else n_pass++;
    tick();
    n_checks++; if (rf_obs[9] !== 32'h2) $display("FAIL samereg_final got %h want 00000002", rf_obs[9]); else n_pass++;
    ptr_m = 2;
  endtask

  task automatic test_random();
    bit            pend [NS];
    logic [AW-1:0] pa [NS];
    logic [DW-1:0] pd [NS];
    int            waitc [NS];
    logic [DW-1:0] rf_m [32];
    bit            wr [32];
    logic [NS-1:0] vmask, exp_rdy;
    int            w;
    for (int i = 0; i < NS; i++) begin pend[i] = 0; pa[i] = '0; pd[i] = '0; waitc[i] = 0; end
    for (int r = 0; r < 32; r++) begin wr[r] = 0; rf_m[r] = '0; end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1;
          pa[i]    = AW'($urandom_range(0, 31));
          pd[i]    = $urandom;
          waitc[i] = 0;
        end
        vmask[i] = pend[i];
        set_src(i, pend[i], pa[i], pd[i]);
      end
      #1;
      w       = model_win(vmask, ptr_m);
      exp_rdy = (w >= 0) ? (NS'(1) << w) : '0;
      n_checks++; if (req_ready !== exp_rdy) $display("FAIL rand_ready c=%0d got %b want %b", c, req_ready, exp_rdy); else n_pass++;
      for (int i = 0; i < NS; i++) if (pend[i] && i != w) waitc[i]++;
      tick();
      if (w >= 0) begin
        n_checks++; if (waitc[w] > NS - 1) $display("FAIL rand_wait src=%0d got %0d want <=%0d", w, waitc[w], NS - 1); else n_pass++;
        n_checks++; if (we !== (pa[w] != '0) || grant_id !== GW'(w) || addr_rd2 !== pa[w] || data_rd2 !== pd[w])
          $display("FAIL rand_write c=%0d got we=%b gid=%0d addr=%0d data=%h want %b/%0d/%0d/%h",
                   c, we, grant_id, addr_rd2, data_rd2, pa[w] != '0, w, pa[w], pd[w]);
        else n_pass++;
        $display("txn c=%0d src=%0d addr=%0d data=%h", c, w, pa[w], pd[w]);
        if (pa[w] != '0) begin rf_m[pa[w]] = pd[w]; wr[pa[w]] = 1; end
        pend[w] = 0;
        ptr_m   = (w + 1) % NS;
      end else begin
        n_checks++; if (we !== 1'b0) $display("FAIL rand_idle c=%0d got we=%b want 0", c, we); else n_pass++;
      end
    end
    req_valid = '0;
    tick();
    tick();
    for (int r = 1; r < 32; r++) begin
      if (wr[r]) begin
        n_checks++; if (rf_obs[r] !== rf_m[r]) $display("FAIL rand_rf x%0d got %h want %h", r, rf_obs[r], rf_m[r]); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_scrub();
    int n;
    set_src(0, 1'b1, 5'd5, 32'h5555_5555);
    set_src(1, 1'b0, 5'd0, 32'd0);
    set_src(2, 1'b0, 5'd0, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (we !== 1'b0 || addr_rd2 !== '0 || data_rd2 !== '0 || grant_id !== '0 || busy !== 1'b1 || req_ready !== '0)
      $display("FAIL midrun_reset got we=%b addr=%0d data=%h gid=%0d busy=%b rdy=%b want 0/0/0/0/1/000",
               we, addr_rd2, data_rd2, grant_id, busy, req_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (addr_rd2 !== 5'd12 && n < 40) begin tick(); n++; end
    n_checks++; if (n != 12) $display("FAIL midscrub_reach12 got %0d cycles want 12", n); else n_pass++;
`ifdef REGFILE_WB_STATS_EN
    n_checks++; if (stall_cnt[15:0] !== 16'd12) $display("FAIL stall_cnt_src0 got %0d want 12", stall_cnt[15:0]); else n_pass++;
`endif
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (we !== 1'b0 || addr_rd2 !== '0 || data_rd2 !== '0 || busy !== 1'b1 || req_ready !== '0)
      $display("FAIL midscrub_reset got we=%b addr=%0d data=%h busy=%b rdy=%b want 0/0/0/1/000", we, addr_rd2, data_rd2, busy, req_ready);
    else n_pass++;
`ifdef REGFILE_WB_STATS_EN
    n_checks++; if (stall_cnt !== '0) $display("FAIL stall_cnt_reset got %h want 0", stall_cnt); else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_checks++; if (we !== 1'b1 || addr_rd2 !== 5'd1 || busy !== 1'b1)
      $display("FAIL midscrub_restart got we=%b addr=%0d busy=%b want 1/1/1", we, addr_rd2, busy);
    else n_pass++;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf_obs[r] <= 32'hBAD0_0000 | 32'(r);
    x0_written <= 1'b0;
    test_reset();
    test_scrub();
    test_single_source();
    test_x0_drop();
    test_contention();
    test_same_reg();
    test_random();
    test_reset_mid_scrub();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of register_file (we, addr_rd2, data_rd2) between NUM_SRC write-back requesters, e.g. src0 = ALU, src1 = load unit. Arbitration is round-robin with a valid/ready handshake per source. After reset, a scrub sequencer first writes zero to x1..x31 before any request is accepted. The block sits between the execute/memory stages and register_file.

Parameters:
NUM_SRC, 2, number of write-back requesters (2..4)
ADDR_W, 5, register address width
DATA_W, 32, write data width
CLEAR_ON_RESET, 1, 1 = run the scrub sequence after reset; 0 = enter RUN directly

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  NUM_SRC  per-source write request
req_addr  input  NUM_SRC*ADDR_W  per-source destination register; source i occupies bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_SRC*DATA_W  per-source write data, packed the same way
req_ready  output  NUM_SRC  per-source accept; one-hot or zero
we  output  1  register_file write enable (registered)
addr_rd2  output  ADDR_W  register_file write address (registered)
data_rd2  output  DATA_W  register_file write data (registered)
grant_id  output  $clog2(NUM_SRC)  source index of the last accepted request (registered)
busy  output  1  scrub in progress

Behaviour:
- Reset (rst = 0, asynchronous):
  - we = 0, addr_rd2 = 0, data_rd2 = 0, grant_id = 0.
  - Round-robin pointer = 0, scrub counter = 1.
  - State = CLEAR if CLEAR_ON_RESET, else RUN; busy = (state == CLEAR).
  - req_ready = 0 throughout reset.
- States: CLEAR, RUN.
- CLEAR:
  - req_ready = 0.
  - Each cycle, registers we = 1, addr_rd2 = counter, data_rd2 = 0; counter increments.
  - When counter = 31 is issued, next state = RUN and busy drops on that same edge.
  - Exactly 31 write cycles; x0 is never written.
- RUN, arbitration (combinational):
  - Winner = first i with req_valid[i] = 1, scanning from pointer upward with wrap mod NUM_SRC.
  - req_ready[winner] = 1; all other req_ready = 0; none if no valid.
  - req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- RUN, on an accept edge (valid & ready):
  - we = 1, addr_rd2/data_rd2 = winner's fields, grant_id = winner.
  - Pointer = (winner + 1) mod NUM_SRC.
- RUN, no accept: we = 0 next cycle; addr_rd2/data_rd2 hold; pointer holds.
- Latency: request accepted at edge N appears on the port during cycle N+1; register_file commits at edge N+1. Throughput is one write per cycle.
- A request with addr = 0 is accepted (ready = 1, pointer advances), but we stays 0 for that cycle.
- Simultaneous requests to the same register: granted in round-robin order, so the later write wins.
- A source holding valid with ready = 0 must keep addr/data stable. With all sources continuously valid, each waits at most NUM_SRC - 1 cycles.
- Reset mid-scrub or mid-RUN: immediate return to reset values, and the scrub restarts from x1.

Optional Feature:
REGFILE_WB_STATS_EN:
- Defined: adds output stall_cnt (NUM_SRC*16 bits).
  - Per source, a 16-bit counter increments on every cycle where req_valid = 1 and req_ready = 0, including during CLEAR.
  - Saturates at 0xFFFF; cleared by reset only.
- Undefined: no port, no counters; behaviour is otherwise identical.

Decomposition:
- Package regfile_wb_pkg holds:
  - state enum {CLEAR, RUN}
  - REG_ZERO = 5'd0
  - LAST_REG = 5'd31
  - STALL_CNT_W = 16
- One sub-module, rr_arbiter:
  - Combinational winner/one-hot grant from req_valid plus pointer.
  - Registered pointer update on accept.
  - Reused later for memory-port sharing.

Test Plan:
1. Scrub: release rst with CLEAR_ON_RESET = 1, src0 valid addr = 5 data = 0xAAAA_AAAA.
   - we = 1 for exactly 31 cycles, addr_rd2 = 1..31, data_rd2 = 0, req_ready = 0, busy = 1.
   - Then busy = 0 and src0 is accepted on the first RUN cycle; x5 = 0xAAAA_AAAA.
2. Single source: src1 writes addr = 7 data = 0x1234_5678.
   - Next cycle: we = 1, addr_rd2 = 7, data_rd2 = 0x1234_5678, grant_id = 1.
   - Readback via register_file data_rs0 (addr_rs0 = 7) returns 0x1234_5678.
3. Contention: src0 and src1 both continuously valid (addr = 3/4, data = 0x11/0x22) for 6 cycles after the pointer resets to 0.
   - grant_id sequence 0, 1, 0, 1, 0, 1; req_ready never has two bits set.
4. Same-register conflict: src0 (addr = 9 data = 0x1) and src1 (addr = 9 data = 0x2) valid together, pointer = 0.
   - Final x9 = 0x2.
5. x0 drop: src0 addr = 0 data = 0xDEAD_BEEF.
   - req_ready = 1, we stays 0, pointer advances, x0 reads 0.
6. Reset mid-scrub: assert rst while addr_rd2 = 12.
   - All outputs go to 0 immediately; after release the scrub restarts at addr_rd2 = 1.
   - With REGFILE_WB_STATS_EN, stall_cnt of a waiting source equals the cycles it waited.
